// File: rtl/game_ctrl.sv
// game_ctrl: debounces the direction buttons, sequences menu/play/over and paces step requests.
// Define GAME_CTRL_SPEEDUP_EN to shorten the step period as the score grows.
module game_ctrl #(
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned MOVE_PERIOD = 10_000_000,
    parameter int unsigned MIN_PERIOD  = 2_000_000,
    parameter int unsigned SPEED_STEP  = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       step_ack,
    input  logic       collide,
    input  logic       ate,
    output logic [1:0] game_mode,
    output logic [1:0] choice,
    output logic [3:0] board_w,
    output logic [1:0] dir,
    output logic       start,
    output logic       step_req,
    output logic [7:0] score
);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        MENU = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } mode_t;

    function automatic logic is_reversal(input logic [1:0] want, input logic [1:0] heading);
        return want == {heading[1], ~heading[0]};
    endfunction

    function automatic logic [3:0] width_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4'd6;
            2'd1:    return 4'd8;
            default: return 4'd10;
        endcase
    endfunction

    // Button index: 0 up, 1 down, 2 left, 3 right (also the event priority order)
    logic [3:0]       raw;
    logic [DEB_W-1:0] deb_cnt [4];
    logic [3:0]       deb_lvl;
    logic [3:0]       deb_q;
    logic [3:0]       press;
    logic             ev_vld;
    logic [1:0]       ev_dir;

    assign raw = {right, left, down, up};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
            deb_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!raw[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DEB_MAX)
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
            deb_q <= deb_lvl;
        end
    end

    always_comb begin
        deb_lvl = '0;
        for (int i = 0; i < 4; i++) deb_lvl[i] = (deb_cnt[i] == DEB_MAX);
    end

    assign press = deb_lvl & ~deb_q;

    always_comb begin
        ev_vld = 1'b1;
        ev_dir = DIR_UP;
        if (press[0])      ev_dir = DIR_UP;
        else if (press[1]) ev_dir = DIR_DOWN;
        else if (press[2]) ev_dir = DIR_LEFT;
        else if (press[3]) ev_dir = DIR_RIGHT;
        else               ev_vld = 1'b0;
    end

    mode_t       mode_q,     mode_d;
    logic [1:0]  choice_q,   choice_d;
    logic [3:0]  board_w_q,  board_w_d;
    logic [1:0]  dir_q,      dir_d;
    logic [1:0]  last_dir_q, last_dir_d;
    logic        pend_vld_q, pend_vld_d;
    logic [1:0]  pend_dir_q, pend_dir_d;
    logic        start_q,    start_d;
    logic        step_req_q, step_req_d;
    logic [7:0]  score_q,    score_d;
    logic [31:0] move_cnt_q, move_cnt_d;
    logic [31:0] period;
    logic [31:0] period_m1;

`ifdef GAME_CTRL_SPEEDUP_EN
    logic [39:0] reduction;

    // Subtraction clamps at zero before the floor is applied
    always_comb begin
        reduction = 40'(score_q) * 40'(SPEED_STEP);
        if (reduction >= 40'(MOVE_PERIOD))
            period = 32'd0;
        else
            period = MOVE_PERIOD - reduction[31:0];
        if (period < MIN_PERIOD)
            period = MIN_PERIOD;
    end
`else
    assign period = MOVE_PERIOD;
`endif

    assign period_m1 = (period == 32'd0) ? 32'd0 : period - 32'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MENU;
            choice_q   <= 2'd0;
            board_w_q  <= 4'd10;
            dir_q      <= DIR_RIGHT;
            last_dir_q <= DIR_RIGHT;
            pend_vld_q <= 1'b0;
            pend_dir_q <= DIR_RIGHT;
            start_q    <= 1'b0;
            step_req_q <= 1'b0;
            score_q    <= 8'd0;
            move_cnt_q <= 32'd0;
        end else begin
            mode_q     <= mode_d;
            choice_q   <= choice_d;
            board_w_q  <= board_w_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            pend_vld_q <= pend_vld_d;
            pend_dir_q <= pend_dir_d;
            start_q    <= start_d;
            step_req_q <= step_req_d;
            score_q    <= score_d;
            move_cnt_q <= move_cnt_d;
        end
    end

    always_comb begin
        mode_d     = mode_q;
        choice_d   = choice_q;
        board_w_d  = board_w_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        pend_vld_d = pend_vld_q;
        pend_dir_d = pend_dir_q;
        start_d    = 1'b0;
        step_req_d = step_req_q;
        score_d    = score_q;
        move_cnt_d = move_cnt_q;

        case (mode_q)
            MENU: begin
                if (ev_vld) begin
                    case (ev_dir)
                        DIR_LEFT:  if (choice_q != 2'd0) choice_d = choice_q - 2'd1;
                        DIR_RIGHT: if (choice_q != 2'd2) choice_d = choice_q + 2'd1;
                        DIR_UP: begin
                            board_w_d  = width_of(choice_q);
                            dir_d      = DIR_RIGHT;
                            last_dir_d = DIR_RIGHT;
                            pend_vld_d = 1'b0;
                            score_d    = 8'd0;
                            move_cnt_d = 32'd0;
                            step_req_d = 1'b0;
                            start_d    = 1'b1;
                            mode_d     = PLAY;
                        end
                        default: ;
                    endcase
                end
            end

            PLAY: begin
                if (step_req_q) begin
                    if (step_ack) begin
                        step_req_d = 1'b0;
                        move_cnt_d = 32'd0;
                        last_dir_d = dir_q;
                        pend_vld_d = 1'b0;
                        if (collide) begin
                            mode_d = OVER;
                        end else begin
                            if (ate && score_q != 8'hFF) score_d = score_q + 8'd1;
                            // An event arriving with the ack is the newest one and overrides the slot
                            if (ev_vld) begin
                                if (!is_reversal(ev_dir, dir_q)) dir_d = ev_dir;
                            end else if (pend_vld_q && !is_reversal(pend_dir_q, dir_q)) begin
                                dir_d = pend_dir_q;
                            end
                        end
                    end else if (ev_vld) begin
                        pend_vld_d = 1'b1;
                        pend_dir_d = ev_dir;
                    end
                end else begin
                    if (ev_vld && !is_reversal(ev_dir, last_dir_q)) dir_d = ev_dir;
                    // The start cycle itself does not count toward the first period
                    if (!start_q) begin
                        if (move_cnt_q == period_m1)
                            step_req_d = 1'b1;
                        else
                            move_cnt_d = move_cnt_q + 32'd1;
                    end
                end
            end

            OVER: begin
                if (ev_vld) begin
                    mode_d   = MENU;
                    choice_d = 2'd0;
                end
            end

            default: mode_d = MENU;
        endcase
    end

    assign game_mode = mode_q;
    assign choice    = choice_q;
    assign board_w   = board_w_q;
    assign dir       = dir_q;
    assign start     = start_q;
    assign step_req  = step_req_q;
    assign score     = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed test-plan scenarios plus randomized play, checked every cycle
// against a behavioural model of the game rules.
module tb_game_ctrl;
    localparam int DEB  = 4;
    localparam int MOVE = 16;
    localparam int MINP = 8;
    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       step_ack = 1'b0, collide = 1'b0, ate = 1'b0;
    logic [1:0] game_mode, choice, dir;
    logic [3:0] board_w;
    logic       start, step_req;
    logic [7:0] score;

    always #5 clk = ~clk;

    game_ctrl #(
        .DEB_CYCLES (DEB),
        .MOVE_PERIOD(MOVE),
        .MIN_PERIOD (MINP),
        .SPEED_STEP (STEP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .step_ack (step_ack),
        .collide  (collide),
        .ate      (ate),
        .game_mode(game_mode),
        .choice   (choice),
        .board_w  (board_w),
        .dir      (dir),
        .start    (start),
        .step_req (step_req),
        .score    (score)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model state; buttons indexed 0 up, 1 down, 2 left, 3 right
    int m_mode, m_choice, m_bw, m_dir, m_last, m_pend, m_start, m_req, m_wait, m_score;
    int run [4];
    int heading [4] = '{2, 3, 1, 0};
    int reverse [4] = '{1, 0, 3, 2};

    int k;
    int hold [4];
    int ack_dly;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int exp_period(input int s);
`ifdef GAME_CTRL_SPEEDUP_EN
        int p = MOVE - s * STEP;
        if (p < MINP) p = MINP;
        return p;
`else
        return MOVE + 0 * s;
`endif
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_choice = 0; m_bw = 10; m_dir = 0; m_last = 0;
        m_pend = -1; m_start = 0; m_req = 0; m_wait = 0; m_score = 0;
        for (int i = 0; i < 4; i++) run[i] = 0;
    endfunction

    task automatic model_step();
        int b;
        int want;
        logic [3:0] lv;
        b = -1;
        if (reset) begin
            model_reset();
            return;
        end
        lv = {right, left, down, up};
        // A press fires once, on the cycle after a button has been high DEB cycles in a row
        for (int i = 0; i < 4; i++) if (b < 0 && run[i] == DEB) b = i;
        for (int i = 0; i < 4; i++) run[i] = lv[i] ? run[i] + 1 : 0;
        m_start = 0;
        case (m_mode)
            0: begin
                if (b == 2) m_choice = (m_choice > 0) ? m_choice - 1 : 0;
                else if (b == 3) m_choice = (m_choice < 2) ? m_choice + 1 : 2;
                else if (b == 0) begin
                    m_bw = 6 + 2 * m_choice;
                    m_dir = 0; m_last = 0; m_score = 0; m_pend = -1;
                    m_req = 0; m_wait = exp_period(0) + 1;
                    m_start = 1; m_mode = 1;
                end
            end
            1: begin
                if (m_req && step_ack) begin
                    m_req = 0;
                    m_last = m_dir;
                    if (collide) begin
                        m_mode = 2;
                    end else begin
                        if (ate && m_score < 255) m_score++;
                        want = (b >= 0) ? heading[b] : m_pend;
                        if (want >= 0 && want != reverse[m_last]) m_dir = want;
                        m_wait = exp_period(m_score);
                    end
                    m_pend = -1;
                end else if (m_req) begin
                    if (b >= 0) m_pend = heading[b];
                end else begin
                    if (b >= 0 && heading[b] != reverse[m_last]) m_dir = heading[b];
                    m_wait--;
                    if (m_wait == 0) m_req = 1;
                end
            end
            2: if (b >= 0) begin m_mode = 0; m_choice = 0; end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        check("game_mode", game_mode, m_mode);
        check("choice", choice, m_choice);
        check("board_w", board_w, m_bw);
        check("dir", dir, m_dir);
        check("start", start, m_start);
        check("step_req", step_req, m_req);
        check("score", score, m_score);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: up = v;
            1: down = v;
            2: left = v;
            default: right = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (DEB + 1) tick();
        set_btn(b, 1'b0);
        tick();
    endtask

    // exp < 0: only require that the request eventually arrives
    task automatic wait_req(input string tag, input int exp);
        int n;
        n = 0;
        while (step_req !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (exp < 0) check(tag, step_req, 1);
        else check(tag, n, exp);
    endtask

    task automatic do_ack(input logic c, input logic a);
        step_ack = 1'b1; collide = c; ate = a;
        tick();
        step_ack = 1'b0; collide = 1'b0; ate = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_mode"}, game_mode, 0);
        check({pfx, "_choice"}, choice, 0);
        check({pfx, "_bw"}, board_w, 10);
        check({pfx, "_dir"}, dir, 0);
        check({pfx, "_start"}, start, 0);
        check({pfx, "_req"}, step_req, 0);
        check({pfx, "_score"}, score, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) tick();
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // Debounce: a 3-cycle glitch is ignored, a 10-cycle hold gives one step
        right = 1'b1; repeat (3) tick();
        right = 1'b0; tick();
        right = 1'b1;
        k = 0;
        while (choice == 2'd0 && k < 20) begin tick(); k++; end
        check("deb_latency", k, 5);
        if (k < 10) repeat (10 - k) tick();
        right = 1'b0; tick();
        check("choice_once", choice, 1);
        press(3); press(3);
        check("choice_sat", choice, 2);
        press(2);
        check("choice_dec", choice, 1);

        // Start game with choice 1
        up = 1'b1;
        k = 0;
        while (game_mode != 2'd1 && k < 20) begin tick(); k++; end
        check("start_pulse", start, 1);
        check("start_bw", board_w, 8);
        up = 1'b0;
        wait_req("first_req", 17);
        repeat (2) tick();
        do_ack(1'b0, 1'b0);
        check("req_drop", step_req, 0);

        // Reversal dropped, then a legal turn, both inside the low window
        press(2);
        check("rev_drop", dir, 0);
        press(1);
        check("dir_down", dir, 3);
        wait_req("gap_s0a", exp_period(0) - 12);

        // Pending slot while step_req is high
        press(0); press(3);
        check("dir_frozen", dir, 3);
        do_ack(1'b0, 1'b0);
        check("pend_applied", dir, 0);

        for (int i = 0; i < 3; i++) begin
            wait_req($sformatf("gap_s%0d", i), exp_period(i));
            tick();
            do_ack(1'b0, 1'b1);
        end
        check("score3", score, 3);
        wait_req("gap_s3", exp_period(3));
        do_ack(1'b1, 1'b1);
        check("over_mode", game_mode, 2);
        check("over_score", score, 3);
        press(1);
        check("menu_mode", game_mode, 0);
        check("menu_choice", choice, 0);

        // Second game to score 5, then reset with a request outstanding
        press(0);
        check("g2_bw", board_w, 6);
        wait_req("g2_first", -1);
        do_ack(1'b0, 1'b1);
        for (int i = 1; i < 5; i++) begin
            wait_req($sformatf("g2_gap_s%0d", i), exp_period(i));
            do_ack(1'b0, 1'b1);
        end
        wait_req("g2_gap_s5", exp_period(5));
        check("g2_score", score, 5);
        reset = 1'b1;
        tick();
        check_reset_values("midrst");
        reset = 1'b0;
        step_ack = 1'b1; collide = 1'b1;
        tick();
        step_ack = 1'b0; collide = 1'b0;
        check("late_ack_mode", game_mode, 0);

        // Randomized play
        for (int i = 0; i < 4; i++) hold[i] = 0;
        ack_dly = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    logic lvl;
                    lvl = ($urandom_range(0, 2) == 0);
                    hold[b] = lvl ? $urandom_range(1, 8) : $urandom_range(1, 12);
                    set_btn(b, lvl);
                end else begin
                    hold[b]--;
                end
            end
            step_ack = 1'b0;
            collide = $urandom_range(0, 1);
            ate = $urandom_range(0, 1);
            if (m_req == 1) begin
                if (ack_dly == 0) begin
                    step_ack = 1'b1;
                    collide = ($urandom_range(0, 15) == 0);
                    ack_dly = $urandom_range(0, 4);
                end else begin
                    ack_dly--;
                end
            end else if ($urandom_range(0, 31) == 0) begin
                step_ack = 1'b1;
            end
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end

        reset = 1'b0; step_ack = 1'b0; collide = 1'b0; ate = 1'b0;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game sequencer for the snake VGA design. It debounces the four direction buttons and runs the menu → play → game-over state machine. It also owns the board-size selection and generates the paced step requests that advance the snake datapath. The snake/apple datapath and the pixel renderer consume its outputs; it never touches pixel coordinates.

## Interface
- `DEB_CYCLES`, default 1_000_000: consecutive high cycles before a raw button counts as pressed.
- `MOVE_PERIOD`, default 10_000_000: cycles between step requests at score 0.
- `MIN_PERIOD`, default 2_000_000: floor on the step period (used only with speed-up).
- `SPEED_STEP`, default 500_000: period reduction per point (used only with speed-up).
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `up`, `down`, `left`, `right` in 1 each: raw button levels, already synchronous to `clk`.
- `step_ack` in 1: datapath finished the requested step; `collide`/`ate` are valid in this cycle only.
- `collide` in 1: the step hit a wall or the snake body.
- `ate` in 1: the step consumed the apple.
- `game_mode` out 2: 00 menu, 01 play, 10 over.
- `choice` out 2: menu highlight, 0..2.
- `board_w` out 4: board width in cells, one of 6, 8 or 10.
- `dir` out 2: 00 right, 01 left, 10 up, 11 down.
- `start` out 1: one-cycle pulse; the datapath reinitialises the snake and apple.
- `step_req` out 1: level; held until `step_ack`.
- `score` out 8: apples eaten this game.

## Operation
- Debounce:
  - Each button has its own counter. It increments while the raw level is high and clears when the level is low.
  - The debounced level rises when the count reaches `DEB_CYCLES`.
  - A press event is a one-cycle pulse on a debounced rising edge. Holding a button gives exactly one event.
  - If events coincide in one cycle, only one is taken, with priority up > down > left > right.
- MENU:
  - left: `choice` decrements, saturating at 0.
  - right: `choice` increments, saturating at 2.
  - down: ignored.
  - up: `board_w` is set to 6, 8 or 10 for `choice` 0, 1, 2. Also `dir`=00, `score`=0, move counter cleared, `start` pulsed. Then go to PLAY.
- PLAY:
  - The move counter runs from 0. When it reaches period−1, `step_req` is asserted and the counter stops.
  - On `step_ack` with `step_req` high:
    - `step_req` drops.
    - The counter restarts at 0.
    - `last_dir` captures `dir`.
    - If `collide`, go to OVER. This takes precedence over `ate`, and `score` is then unchanged.
    - Else if `ate`, `score` increments, saturating at 255.
  - Direction events while `step_req` is low:
    - `dir` updates unless the event is the opposite of `last_dir`. Reversals are dropped silently.
  - Direction events while `step_req` is high:
    - `dir` is frozen.
    - The latest event is stored in a one-entry pending slot, overwriting any earlier one.
    - The slot is applied, with the reversal check, in the cycle after the ack, then cleared.
    - The slot is cleared on leaving PLAY.
- OVER:
  - `step_req` is low.
  - Any press event: go to MENU with `choice`=0. `board_w` and `score` hold.
- `step_ack` is ignored outside PLAY and when `step_req` is low.

## Timing
- Reset values:
  - `game_mode`=00, `choice`=0, `board_w`=10, `dir`=00, `start`=0, `step_req`=0, `score`=0.
  - All debounce counters, the move counter and the pending slot are cleared; `last_dir`=00.
- Reset mid-game, including with `step_req` high: the next cycle shows the reset values. The outstanding request is abandoned.
- Debounce latency: an event pulses `DEB_CYCLES`+1 cycles after the raw level rises.
- State-change latency: one cycle from the event to the change in `choice`, `game_mode` or `dir`.
- `start`: high in the first cycle that `game_mode`=01.
- `step_req`: rises in the cycle after the counter equals period−1, so the first request comes period+1 cycles after `start`.
  - `dir` is stable from the rise of `step_req` until the cycle after `step_ack`.
- Ack response: `step_ack` at cycle t gives `step_req` low at t+1 and `game_mode`/`score` updated at t+1.
- The move counter is 32 bits. The period is computed unsigned, with the subtraction clamped at 0 before applying the floor.

## Configuration
- `GAME_CTRL_SPEEDUP_EN` defined:
  - period = max(`MIN_PERIOD`, `MOVE_PERIOD` − `score`×`SPEED_STEP`).
  - It is recomputed on every counter restart, so it uses the updated score.
- Undefined: period is always `MOVE_PERIOD`. `MIN_PERIOD` and `SPEED_STEP` are unused.

## Test plan
All scenarios use `DEB_CYCLES`=4 and `MOVE_PERIOD`=16.
- Debounce: `right` high for 3 cycles, low, then high for 10 cycles in MENU → `choice` goes to 1 exactly once, 5 cycles after the second rise. Repeat twice more → `choice` stays at 2.
- Start game: `choice`=1, press up → `board_w`=8, `game_mode`=01, `start` high for exactly 1 cycle. First `step_req` 17 cycles after `start`, held until the ack is returned 3 cycles later.
- Reversal and pending slot:
  - `last_dir`=00, press left → `dir` stays 00.
  - Press down → `dir`=11.
  - While `step_req` is high, press up then right → `dir` frozen, and `dir`=00 one cycle after the ack.
- Score and game over:
  - Ack with `ate`=1 three times → `score`=3.
  - Ack with `collide`=1 and `ate`=1 → `game_mode`=10 and `score` stays 3.
  - Any press → MENU with `choice`=0.
- Speed-up: with `GAME_CTRL_SPEEDUP_EN`, `MIN_PERIOD`=8 and `SPEED_STEP`=4 → gaps between requests are 16, 12 and 8 cycles at scores 0, 1, 2, and stay at 8 at score 5. Without the macro → always 16.
- Reset: assert `reset` while `step_req` is high with `score`=5 → next cycle shows all reset values, and an ack arriving afterwards is ignored.
